rucksack_line_parser: RTL and testbench

- Upstream stage of the day-3 rucksack datapath. Streams ASCII bytes from the puzzle ROM and splits each line into its two compartments.
- Emits one pair of 64-bit item bitmaps per line, half1 and half2, on a valid/ready handshake.
- The downstream comparator/priority-accumulator ANDs the pair and sums the priority of the set bit.

---
 rtl/rucksack_pkg.sv | 38 +++
 rtl/rucksack_bitmap_acc.sv | 39 +++
 rtl/rucksack_line_parser.sv | 178 +++++++++++++++++
 tb/tb_rucksack_line_parser.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rucksack_pkg.sv
// Shared types and helpers for the rucksack line parser: bitmap width, ASCII
// control characters, FSM state encoding and the letter-to-priority mapping.
package rucksack_pkg;

   localparam int BITMAP_W = 64;

   localparam logic [7:0] LF  = 8'h0A;
   localparam logic [7:0] CR  = 8'h0D;
   localparam logic [7:0] NUL = 8'h00;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_SPLIT,
      ST_OUT,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic       is_letter;
      logic [5:0] idx;
   } item_t;

   // Bit index equals item priority: 'a'..'z' -> 1..26, 'A'..'Z' -> 27..52.
   function automatic item_t char_to_bit(input logic [7:0] c);
      item_t r;
      r.is_letter = 1'b0;
      r.idx       = 6'd0;
      if (c >= 8'h61 && c <= 8'h7A) begin
         r.is_letter = 1'b1;
         r.idx       = 6'(c - 8'd96);
      end else if (c >= 8'h41 && c <= 8'h5A) begin
         r.is_letter = 1'b1;
         r.idx       = 6'(c - 8'd38);
      end
      return r;
   endfunction

endpackage

// File: rtl/rucksack_bitmap_acc.sv
// Clear/OR accumulator for one 64-bit item bitmap; result visible one cycle
// after clr_i/set_i, clear wins over set, no backpressure.
module rucksack_bitmap_acc
   import rucksack_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_i,
   input  logic                set_i,
   input  logic [5:0]          idx_i,
   output logic [BITMAP_W-1:0] bitmap_o
);

   logic [BITMAP_W-1:0] bitmap_q;
   logic [BITMAP_W-1:0] bitmap_d;
   logic [BITMAP_W-1:0] onehot;

   always_comb begin
      onehot        = '0;
      onehot[idx_i] = 1'b1;
      bitmap_d      = bitmap_q;
      if (clr_i) begin
         bitmap_d = '0;
      end else if (set_i) begin
         bitmap_d = bitmap_q | onehot;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitmap_q <= '0;
      end else begin
         bitmap_q <= bitmap_d;
      end
   end

   assign bitmap_o = bitmap_q;

endmodule

// File: rtl/rucksack_line_parser.sv
// Streams ROM bytes into a line buffer and emits half1/half2 item bitmaps per line; out_valid
// at T+L+1, held with rom_addr frozen while out_ready is low. RUCKSACK_LINE_BITMAP_EN adds line_bitmap.
module rucksack_line_parser
   import rucksack_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int ROM_DEPTH = 4096,
   parameter int MAX_LINE  = 64
) (
   input  logic                clk,
   input  logic                rst,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [7:0]          rom_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BITMAP_W-1:0] half1,
   output logic [BITMAP_W-1:0] half2,
   output logic                line_err,
`ifdef RUCKSACK_LINE_BITMAP_EN
   output logic [BITMAP_W-1:0] line_bitmap,
`endif
   output logic                done
);

   localparam int                LEN_W     = $clog2(MAX_LINE + 1);
   localparam int                IDX_W     = $clog2(MAX_LINE);
   localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_LINE);
   localparam logic [LEN_W-1:0]  ONE       = LEN_W'(1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [ADDR_W-1:0] data_addr_q;
   logic              rd_vld_q;
   logic [LEN_W-1:0]  len_q, len_d, len_new;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic              eod_q, eod_d;
   logic              err_q, err_d;
   logic [5:0]        buf_q [MAX_LINE];

   item_t             item;
   logic [5:0]        rd_item;
   logic              buf_we, acc_clr, set1, set2, eod_now;

   assign item    = char_to_bit(rom_data);
   assign rd_item = buf_q[idx_q[IDX_W-1:0]];

   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      len_d      = len_q;
      len_new    = len_q;
      idx_d      = idx_q;
      eod_d      = eod_q;
      err_d      = err_q;
      buf_we     = 1'b0;
      acc_clr    = 1'b0;
      set1       = 1'b0;
      set2       = 1'b0;
      eod_now    = 1'b0;
      case (state_q)
         ST_FILL: begin
            // Address runs one ahead of the byte being classified.
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            if (rd_vld_q) begin
               if (item.is_letter) begin
                  if (len_q < MAX_LEN) begin
                     buf_we  = 1'b1;
                     len_new = len_q + ONE;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (rom_data != LF && rom_data != CR && rom_data != NUL) begin
                  err_d = 1'b1;
               end
               eod_now = (rom_data == NUL) || (data_addr_q == LAST_ADDR);
               if (eod_now || rom_data == LF) begin
                  if (len_new != '0) begin
                     state_d = ST_SPLIT;
                     acc_clr = 1'b1;
                     idx_d   = '0;
                     eod_d   = eod_now;
                     if (len_new[0]) begin
                        err_d = 1'b1;
                     end
                  end else if (eod_now) begin
                     state_d = ST_DONE;
                  end
               end
               len_d = len_new;
            end
         end
         ST_SPLIT: begin
            if (idx_q < (len_q >> 1)) begin
               set1 = 1'b1;
            end else begin
               set2 = 1'b1;
            end
            idx_d = idx_q + ONE;
            if (idx_q == len_q - ONE) begin
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               len_d = '0;
               if (eod_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d    = ST_FILL;
                  rom_addr_d = rom_addr_q - ADDR_W'(1);
               end
            end
         end
         ST_DONE: begin
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_FILL;
         rom_addr_q  <= '0;
         data_addr_q <= '0;
         rd_vld_q    <= 1'b0;
         len_q       <= '0;
         idx_q       <= '0;
         eod_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rom_addr_q  <= rom_addr_d;
         data_addr_q <= rom_addr_q;
         rd_vld_q    <= (state_q == ST_FILL);
         len_q       <= len_d;
         idx_q       <= idx_d;
         eod_q       <= eod_d;
         err_q       <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_q[len_q[IDX_W-1:0]] <= item.idx;
      end
   end

   rucksack_bitmap_acc u_half1 (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (acc_clr),
      .set_i    (set1),
      .idx_i    (rd_item),
      .bitmap_o (half1)
   );

   rucksack_bitmap_acc u_half2 (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (acc_clr),
      .set_i    (set2),
      .idx_i    (rd_item),
      .bitmap_o (half2)
   );

   assign rom_addr  = rom_addr_q;
   assign out_valid = (state_q == ST_OUT);
   assign done      = (state_q == ST_DONE);
   assign line_err  = err_q;

`ifdef RUCKSACK_LINE_BITMAP_EN
   assign line_bitmap = out_valid ? (half1 | half2) : '0;
`endif

endmodule

// File: tb/tb_rucksack_line_parser.sv
// Scoreboard bench for rucksack_line_parser: directed ROM images, expected pairs queued
// at stimulus time and popped by a monitor on every accepted output.
module tb_rucksack_line_parser;

   localparam int ADDR_W    = 12;
   localparam int ROM_DEPTH = 4096;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] rom_addr;
   logic [7:0]        rom_data;
   logic              out_valid;
   logic              out_ready;
   logic [63:0]       half1;
   logic [63:0]       half2;
   logic              line_err;
   logic              done;
`ifdef RUCKSACK_LINE_BITMAP_EN
   logic [63:0]       line_bitmap;
`endif

   logic [7:0]   rom [ROM_DEPTH];
   logic [127:0] exp_q [$];
   logic [127:0] mon_exp;
   int           n_cmp = 0;
   int           n_bad = 0;

   rucksack_line_parser #(
      .ADDR_W    (ADDR_W),
      .ROM_DEPTH (ROM_DEPTH),
      .MAX_LINE  (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .half1     (half1),
      .half2     (half2),
      .line_err  (line_err),
`ifdef RUCKSACK_LINE_BITMAP_EN
      .line_bitmap (line_bitmap),
`endif
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) rom_data <= rom[rom_addr];

   function automatic logic [63:0] b(input int n);
      return 64'd1 << n;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pair: got %0h / %0h, expected no pair", half1, half2);
         end else begin
            mon_exp = exp_q.pop_front();
            check("pair_half1", 128'(half1), 128'(mon_exp[127:64]));
            check("pair_half2", 128'(half2), 128'(mon_exp[63:0]));
`ifdef RUCKSACK_LINE_BITMAP_EN
            check("pair_bitmap", 128'(line_bitmap), 128'(mon_exp[127:64] | mon_exp[63:0]));
`endif
         end
      end
   end

   task automatic load_rom(input logic [7:0] fill, input int base, input string s);
      for (int i = 0; i < ROM_DEPTH; i++) rom[i] = fill;
      for (int i = 0; i < s.len(); i++) rom[ADDR_W'(base + i)] = s[i];
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rom_addr", 128'(rom_addr), 128'd0);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_half1", 128'(half1), 128'd0);
      check("rst_half2", 128'(half2), 128'd0);
      check("rst_line_err", 128'(line_err), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (done) break;
         @(posedge clk);
         #1;
      end
      check(name, 128'(done), 128'd1);
   endtask

   task automatic measure_latency(output int cyc);
      cyc = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) break;
         cyc++;
      end
   endtask

   task automatic finish_test(input string name, input logic err_exp);
      check({name, "_drained"}, 128'(exp_q.size()), 128'd0);
      check({name, "_line_err"}, 128'(line_err), 128'(err_exp));
   endtask

   initial begin
      int          cyc;
      logic [63:0] t1_h1;
      logic [63:0] t1_h2;
      rst       = 1'b1;
      out_ready = 1'b1;
      // "vJrwpWtwJgWr" / "hcsFMMfFFhFp": common item is 'p'
      t1_h1 = b(22) | b(36) | b(18) | b(23) | b(16) | b(49) | b(20) | b(7);
      t1_h2 = b(8) | b(3) | b(19) | b(32) | b(39) | b(6) | b(16);

      load_rom(8'h00, 0, "vJrwpWtwJgWrhcsFMMfFFhFp\n");
      exp_q.push_back({t1_h1, t1_h2});
      do_reset();
      measure_latency(cyc);
      check("t1_latency", 128'(cyc), 128'd49);
      check("t1_common", 128'(half1 & half2), 128'(b(16)));
      wait_done("t1_done", 100);
      finish_test("t1", 1'b0);

      load_rom(8'h00, 0, "ab\ncd\n");
      exp_q.push_back({b(1), b(2)});
      exp_q.push_back({b(3), b(4)});
      out_ready = 1'b0;
      do_reset();
      for (int k = 0; k < 100; k++) begin
         if (out_valid) break;
         @(posedge clk);
         #1;
      end
      check("t2_valid", 128'(out_valid), 128'd1);
      check("t2_addr_frozen", 128'(rom_addr), 128'd4);
      repeat (20) begin
         @(posedge clk);
         #1;
         check("t2_hold_valid", 128'(out_valid), 128'd1);
         check("t2_hold_half1", 128'(half1), 128'(b(1)));
         check("t2_hold_half2", 128'(half2), 128'(b(2)));
         check("t2_hold_addr", 128'(rom_addr), 128'd4);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t2_after_valid", 128'(out_valid), 128'd0);
      check("t2_rewind_addr", 128'(rom_addr), 128'd3);
      wait_done("t2_done", 100);
      finish_test("t2", 1'b0);

      load_rom(8'h00, 0, "ab\n\nCD\r\n");
      exp_q.push_back({b(1), b(2)});
      exp_q.push_back({b(29), b(30)});
      do_reset();
      wait_done("t3_done", 100);
      finish_test("t3", 1'b0);

      load_rom(8'h00, 0, "abc\n");
      exp_q.push_back({b(1), b(2) | b(3)});
      do_reset();
      wait_done("t4_done", 100);
      finish_test("t4", 1'b1);

      load_rom(8'h0A, ROM_DEPTH - 2, "aA");
      exp_q.push_back({b(1), b(27)});
      do_reset();
      wait_done("t5_done", 5000);
      finish_test("t5", 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check("t5_done_hold", 128'(done), 128'd1);
      check("t5_no_valid", 128'(out_valid), 128'd0);

      load_rom(8'h00, 0, "vJrwpWtwJgWrhcsFMMfFFhFp\n");
      do_reset();
      repeat (35) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("t6_rom_addr", 128'(rom_addr), 128'd0);
      check("t6_out_valid", 128'(out_valid), 128'd0);
      check("t6_half1", 128'(half1), 128'd0);
      check("t6_half2", 128'(half2), 128'd0);
      check("t6_line_err", 128'(line_err), 128'd0);
      check("t6_done", 128'(done), 128'd0);
      exp_q.push_back({t1_h1, t1_h2});
      @(negedge clk);
      rst = 1'b0;
      measure_latency(cyc);
      check("t6_latency", 128'(cyc), 128'd49);
      wait_done("t6_done_flag", 100);
      finish_test("t6", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
